// File: rtl/zhegalkin_sweep_ctrl.sv
// Sweeps all 2^N input vectors through an external Boolean evaluator, captures the
// truth table, then runs an in-place Reed-Muller transform (one pass per cycle) to get the ANF.
module zhegalkin_sweep_ctrl #(
    parameter int N = 4,
    localparam int W = 1 << N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] x_out,
    input  logic         y_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] truth_table,
    output logic [W-1:0] anf
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, XFORM, DONE} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  x_reg, x_next;
    logic [KW-1:0] k_reg, k_next;
    logic [W-1:0]  work_reg, work_next;
    logic [W-1:0]  tt_reg, tt_next;
    logic [W-1:0]  anf_reg, anf_next;

    // Every possible pass result is built in parallel; the pass counter picks one.
    logic [W-1:0]  pass_vec [N];

    genvar gk, gi;
    generate
        for (gk = 0; gk < N; gk++) begin : g_pass
            for (gi = 0; gi < W; gi++) begin : g_bit
                if (((gi >> gk) & 1) != 0) begin : g_xor
                    assign pass_vec[gk][gi] = work_reg[gi] ^ work_reg[gi ^ (1 << gk)];
                end else begin : g_keep
                    assign pass_vec[gk][gi] = work_reg[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        k_next     = k_reg;
        work_next  = work_reg;
        tt_next    = tt_reg;
        anf_next   = anf_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SWEEP;
                    x_next     = '0;
                    k_next     = '0;
                    work_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            SWEEP: begin
                work_next[x_reg] = y_in;
                x_next           = x_reg + N'(1);
                if (&x_reg) begin
                    tt_next    = work_next;
                    x_next     = '0;
                    k_next     = '0;
                    state_next = XFORM;
                end
            end
            XFORM: begin
                work_next = pass_vec[k_reg];
                k_next    = k_reg + KW'(1);
                if (k_reg == KW'(N - 1)) begin
                    anf_next   = pass_vec[k_reg];
                    k_next     = '0;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            k_reg     <= '0;
            work_reg  <= '0;
            tt_reg    <= '0;
            anf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            k_reg     <= k_next;
            work_reg  <= work_next;
            tt_reg    <= tt_next;
            anf_reg   <= anf_next;
        end
    end

    assign x_out       = x_reg;
    assign busy        = (state_reg == SWEEP) || (state_reg == XFORM);
    assign done        = (state_reg == DONE);
    assign truth_table = tt_reg;
    assign anf         = anf_reg;

endmodule

// File: tb/tb_zhegalkin_sweep_ctrl.sv
// Bench for zhegalkin_sweep_ctrl: table of evaluator functions with known truth tables and
// ANF vectors, a result scoreboard, and hand-written restart/reset/back-to-back sequences.
module tb_zhegalkin_sweep_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // N = 4 instance
    logic        rst4, start4, y4, busy4, done4;
    logic [3:0]  x4;
    logic [15:0] tt4, anf4;
    int          fn4 = 0;

    // N = 2 instance
    logic        rst2, start2, y2, busy2, done2;
    logic [1:0]  x2;
    logic [3:0]  tt2, anf2;

    zhegalkin_sweep_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .x_out(x4), .y_in(y4),
        .busy(busy4), .done(done4), .truth_table(tt4), .anf(anf4)
    );

    zhegalkin_sweep_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .x_out(x2), .y_in(y2),
        .busy(busy2), .done(done2), .truth_table(tt2), .anf(anf2)
    );

    function automatic logic eval4(input int fn, input logic [3:0] x);
        case (fn)
            0: return 1'b1 ^ x[0] ^ x[2] ^ x[3] ^ (x[0] & x[2]) ^ (x[1] & x[2])
                      ^ (x[2] & x[3]) ^ (x[1] & x[2] & x[3]);
            1: return x[0];
            2: return 1'b1;
            3: return 1'b0;
            4: return &x;
            5: return ^x;
            default: return 1'b0;
        endcase
    endfunction

    assign y4 = eval4(fn4, x4);
    assign y2 = x2[0] & x2[1];

    typedef struct {
        int          fn;
        logic [15:0] tt;
        logic [15:0] anf;
    } vec_t;

    typedef struct {
        logic [15:0] tt;
        logic [15:0] anf;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One N=4 run; optional extra start pulses at cycles p1/p2 and reset at cycle rst_k.
    task automatic run4(input int fn, input logic [15:0] ett, input logic [15:0] eanf,
                        input int p1, input int p2, input int rst_k);
        exp_t e, got_e;
        int   busy_n;
        bit   got;
        fn4   = fn;
        e.tt  = ett;
        e.anf = eanf;
        e.lat = 20;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        check("x_out_k0", 32'(x4), 32'd0);
        busy_n = int'(busy4);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rst4) begin
                rst4 = 1'b0;
                check("rst_outputs", {x4, busy4, done4, tt4, anf4}, 32'd0);
                void'(exp_q.pop_back());
                return;
            end
            if (k <= 16) check("x_out_seq", 32'(x4), 32'(k % 16));
            if (done4) begin
                got   = 1'b1;
                got_e = exp_q.pop_front();
                $display("[TB] run fn=%0d done at cycle %0d tt=%h anf=%h", fn, k, tt4, anf4);
                check("truth_table", 32'(tt4), 32'(got_e.tt));
                check("anf", 32'(anf4), 32'(got_e.anf));
                check("done_latency", 32'(k), 32'(got_e.lat));
                check("busy_cycles", 32'(busy_n), 32'd20);
                check("busy_in_done", 32'(busy4), 32'd0);
            end else begin
                busy_n += int'(busy4);
            end
            start4 = (k == p1) || (k == p2);
            if (k == rst_k) rst4 = 1'b1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_done", {busy4, done4}, 32'd0);
    endtask

    initial begin
        vec_t vecs [6];
        int   done_times[$];
        int   hold_exp [3];
        int   stable_bad;
        int   done2_k;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int   done_times[$];
        int   hold_exp [3];
        int   stable_bad;
        int   done2_k;

        vecs[0] = '{0, 16'h0AC5, 16'h5173};
        vecs[1] = '{1, 16'hAAAA, 16'h0002};
        vecs[2] = '{2, 16'hFFFF, 16'h0001};
        vecs[3] = '{3, 16'h0000, 16'h0000};
        vecs[4] = '{4, 16'h8000, 16'h8000};
        vecs[5] = '{5, 16'h6996, 16'h0116};
        hold_exp = '{20, 41, 62};

        rst4 = 1'b1; start4 = 1'b1; rst2 = 1'b1; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state4", {x4, busy4, done4, tt4, anf4}, 32'd0);
        check("reset_state2", {x2, busy2, done2, tt2, anf2}, 32'd0);
        rst4 = 1'b0; start4 = 1'b0; rst2 = 1'b0;

        foreach (vecs[i]) run4(vecs[i].fn, vecs[i].tt, vecs[i].anf, 0, 0, 0);

        // Start pulses during SWEEP cycle 5 and XFORM pass 2 must be ignored.
        run4(0, 16'h0AC5, 16'h5173, 5, 18, 0);

        // Reset mid-sweep, then a clean run.
        run4(5, 16'h6996, 16'h0116, 0, 0, 9);
        run4(0, 16'h0AC5, 16'h5173, 0, 0, 0);

        // start held high: back-to-back runs with a single DONE cycle between them.
        fn4 = 5;
        stable_bad = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done4) begin
                done_times.push_back(k);
                $display("[TB] hold run done at cycle %0d", k);
            end
            if (k >= 17 && tt4 !== 16'h6996) stable_bad++;
            if (k >= 21 && anf4 !== 16'h0116) stable_bad++;
            if (k == 59) start4 = 1'b0;
        end
        check("hold_done_count", 32'(done_times.size()), 32'd3);
        for (int i = 0; i < 3 && i < done_times.size(); i++)
            check("hold_done_time", 32'(done_times[i]), 32'(hold_exp[i]));
        check("hold_results_stable", 32'(stable_bad), 32'd0);

        // N = 2, y = x0 & x1.
        done2_k = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 1; k <= 15 && done2_k == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2) done2_k = k;
        end
        $display("[TB] N=2 run done at cycle %0d tt=%h anf=%h", done2_k, tt2, anf2);
        check("n2_done_latency", 32'(done2_k), 32'd6);
        check("n2_truth_table", 32'(tt2), 32'h8);
        check("n2_anf", 32'(anf2), 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
